// File: rtl/motion_pkg.sv
// Shared types, channel map and saturation helpers for the line-follower steering path.
package motion_pkg;

   localparam int unsigned RES_W  = 12;
   localparam int unsigned ACC_W  = 16;
   localparam int unsigned ERR_W  = 12;
   localparam int unsigned DUTY_W = 11;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned WIDE_W = 17;
   localparam int unsigned DRV_W  = 14;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CNV_R  = 3'd2,
      WAIT_R = 3'd3,
      CNV_L  = 3'd4,
      WAIT_L = 3'd5,
      CALC   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      PAIR_IN  = 2'd0,
      PAIR_MID = 2'd1,
      PAIR_OUT = 2'd2
   } pair_t;

   // A2D channel assignment of each sensor pair
   localparam logic [CH_W-1:0] CH_IN_R  = 3'd1;
   localparam logic [CH_W-1:0] CH_IN_L  = 3'd0;
   localparam logic [CH_W-1:0] CH_MID_R = 3'd4;
   localparam logic [CH_W-1:0] CH_MID_L = 3'd2;
   localparam logic [CH_W-1:0] CH_OUT_R = 3'd3;
   localparam logic [CH_W-1:0] CH_OUT_L = 3'd7;

   // Weight of each pair expressed as a left shift (x1, x2, x4)
   localparam logic [1:0] SH_IN  = 2'd0;
   localparam logic [1:0] SH_MID = 2'd1;
   localparam logic [1:0] SH_OUT = 2'd2;

   localparam logic signed [WIDE_W-1:0] SAT_HI = 17'sd2047;
   localparam logic signed [WIDE_W-1:0] SAT_LO = -17'sd2048;
   localparam logic signed [DRV_W-1:0]  DUTY_HI = 14'sd2047;

   function automatic logic [CH_W-1:0] pair_rchn(input pair_t p);
      case (p)
         PAIR_IN:  return CH_IN_R;
         PAIR_MID: return CH_MID_R;
         default:  return CH_OUT_R;
      endcase
   endfunction

   function automatic logic [CH_W-1:0] pair_lchn(input pair_t p);
      case (p)
         PAIR_IN:  return CH_IN_L;
         PAIR_MID: return CH_MID_L;
         default:  return CH_OUT_L;
      endcase
   endfunction

   function automatic logic [1:0] pair_shift(input pair_t p);
      case (p)
         PAIR_IN:  return SH_IN;
         PAIR_MID: return SH_MID;
         default:  return SH_OUT;
      endcase
   endfunction

   // LED enables packed as {out, mid, in}
   function automatic logic [2:0] pair_led(input pair_t p);
      case (p)
         PAIR_IN:  return 3'b001;
         PAIR_MID: return 3'b010;
         default:  return 3'b100;
      endcase
   endfunction

   function automatic pair_t pair_next(input pair_t p);
      case (p)
         PAIR_IN: return PAIR_MID;
         default: return PAIR_OUT;
      endcase
   endfunction

   // Saturate a wide signed value into 12-bit signed range
   function automatic logic signed [ERR_W-1:0] sat12(input logic signed [WIDE_W-1:0] x);
      if (x > SAT_HI)      return 12'sh7FF;
      else if (x < SAT_LO) return 12'sh800;
      else                 return x[ERR_W-1:0];
   endfunction

   // Clamp a signed drive value into the unsigned 11-bit duty range
   function automatic logic [DUTY_W-1:0] clamp11(input logic signed [DRV_W-1:0] x);
      if (x[DRV_W-1])        return '0;
      else if (x > DUTY_HI)  return 11'h7FF;
      else                   return x[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/motion_seq_if.sv
// A2D, LED and steering signals shared between the sequencer and its environment.
interface motion_seq_if;
   import motion_pkg::*;

   logic              go;
   logic              strt_cnv;
   logic [CH_W-1:0]   chnnl;
   logic              cnv_cmplt;
   logic [RES_W-1:0]  A2D_res;
   logic              IR_in_en;
   logic              IR_mid_en;
   logic              IR_out_en;
   logic [ERR_W-1:0]  error;
   logic [DUTY_W-1:0] lft;
   logic [DUTY_W-1:0] rht;
   logic              err_vld;

   modport master (
      output go, cnv_cmplt, A2D_res,
      input  strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, error, lft, rht, err_vld
   );

   modport slave (
      input  go, cnv_cmplt, A2D_res,
      output strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, error, lft, rht, err_vld
   );

endinterface

// File: rtl/motion_seq_pi_calc.sv
// Decimated integrator and saturating PI steering math; one result per CALC cycle.
module pi_calc
   import motion_pkg::*;
#(
   parameter int unsigned       INT_DEC   = 4,
   parameter logic [DUTY_W-1:0] BASE_DUTY = 11'h3D4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clr,
   input  logic                     i_calc,
   input  logic signed [ACC_W-1:0]  i_accum,
   output logic signed [ERR_W-1:0]  o_error,
   output logic [DUTY_W-1:0]        o_lft,
   output logic [DUTY_W-1:0]        o_rht,
   output logic                     o_vld
);

   localparam int unsigned DEC_W = $clog2(INT_DEC + 1);

   logic [DEC_W-1:0]         r_dec;
   logic signed [ERR_W-1:0]  r_integ;
   logic signed [ERR_W-1:0]  r_error;
   logic [DUTY_W-1:0]        r_lft;
   logic [DUTY_W-1:0]        r_rht;
   logic                     r_vld;

   logic signed [ERR_W-1:0]  w_err;
   logic signed [ERR_W-1:0]  w_err_sh;
   logic signed [ERR_W-1:0]  w_integ_nxt;
   logic signed [ERR_W-1:0]  w_pi;
   logic signed [DRV_W-1:0]  w_lft_raw;
   logic signed [DRV_W-1:0]  w_rht_raw;
   logic                     w_dec_wrap;

   // Error, integrator update (uses the fresh error) and PI sum, all sign-extended before adding
   always_comb begin
      w_err       = sat12({i_accum[ACC_W-1], i_accum});
      w_err_sh    = w_err >>> 4;
      w_dec_wrap  = (r_dec == DEC_W'(INT_DEC - 1));
      w_integ_nxt = r_integ;
      if (w_dec_wrap)
         w_integ_nxt = sat12({{5{r_integ[ERR_W-1]}}, r_integ} + {{5{w_err_sh[ERR_W-1]}}, w_err_sh});
      w_pi      = sat12({{5{w_err[ERR_W-1]}}, w_err} + {{5{w_integ_nxt[ERR_W-1]}}, w_integ_nxt});
      w_lft_raw = {3'b000, BASE_DUTY} + {{2{w_pi[ERR_W-1]}}, w_pi};
      w_rht_raw = {3'b000, BASE_DUTY} - {{2{w_pi[ERR_W-1]}}, w_pi};
   end

   // Result registers; a dropped go wipes the integrator history as well as the outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dec   <= '0;
         r_integ <= '0;
         r_error <= '0;
         r_lft   <= '0;
         r_rht   <= '0;
         r_vld   <= 1'b0;
      end else if (i_clr) begin
         r_dec   <= '0;
         r_integ <= '0;
         r_error <= '0;
         r_lft   <= '0;
         r_rht   <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_vld <= i_calc;
         if (i_calc) begin
            r_dec   <= w_dec_wrap ? '0 : r_dec + DEC_W'(1);
            r_integ <= w_integ_nxt;
            r_error <= w_err;
            r_lft   <= clamp11(w_lft_raw);
            r_rht   <= clamp11(w_rht_raw);
         end
      end
   end

   assign o_error = r_error;
   assign o_lft   = r_lft;
   assign o_rht   = r_rht;
   assign o_vld   = r_vld;

endmodule

// File: rtl/motion_seq.sv
// IR line-sensor sweep sequencer: steps the A2D through three LED pairs and feeds the PI steering.
module motion_seq
   import motion_pkg::*;
#(
   parameter int unsigned       SETTLE_CYCLES = 4096,
   parameter int unsigned       INT_DEC       = 4,
   parameter logic [DUTY_W-1:0] BASE_DUTY     = 11'h3D4
) (
   input  logic         clk,
   input  logic         rst_n,
   motion_seq_if.slave  io_seq
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t                   r_state;
   pair_t                    r_pair;
   logic [SET_W-1:0]         r_set_cnt;
   logic signed [ACC_W-1:0]  r_accum;
   logic                     r_strt_cnv;
   logic [CH_W-1:0]          r_chnnl;
   logic [2:0]               r_led_en;

   logic [ACC_W-1:0]         w_term;
   logic                     w_calc;
   logic                     w_clr;
   logic signed [ERR_W-1:0]  w_error;
   logic [DUTY_W-1:0]        w_lft;
   logic [DUTY_W-1:0]        w_rht;
   logic                     w_vld;

   // Conversion result weighted by the active pair
   always_comb begin
      w_term = {4'b0000, io_seq.A2D_res} << pair_shift(r_pair);
   end

   assign w_calc = (r_state == CALC);
   assign w_clr  = ~io_seq.go;

   // Sweep FSM with settle counter, accumulator and registered A2D/LED controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pair     <= PAIR_IN;
         r_set_cnt  <= '0;
         r_accum    <= '0;
         r_strt_cnv <= 1'b0;
         r_chnnl    <= '0;
         r_led_en   <= '0;
      end else if (!io_seq.go) begin
         r_state    <= IDLE;
         r_pair     <= PAIR_IN;
         r_set_cnt  <= '0;
         r_accum    <= '0;
         r_strt_cnv <= 1'b0;
         r_chnnl    <= '0;
         r_led_en   <= '0;
      end else begin
         r_strt_cnv <= 1'b0;
         case (r_state)
            IDLE: begin
               r_state   <= SETTLE;
               r_pair    <= PAIR_IN;
               r_set_cnt <= '0;
               r_accum   <= '0;
               r_led_en  <= pair_led(PAIR_IN);
            end
            SETTLE: begin
               if (r_set_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                  r_state    <= CNV_R;
                  r_strt_cnv <= 1'b1;
                  r_chnnl    <= pair_rchn(r_pair);
               end else begin
                  r_set_cnt <= r_set_cnt + SET_W'(1);
               end
            end
            CNV_R: r_state <= WAIT_R;
            WAIT_R: begin
               if (io_seq.cnv_cmplt) begin
                  r_accum    <= r_accum + $signed(w_term);
                  r_state    <= CNV_L;
                  r_strt_cnv <= 1'b1;
                  r_chnnl    <= pair_lchn(r_pair);
               end
            end
            CNV_L: r_state <= WAIT_L;
            WAIT_L: begin
               if (io_seq.cnv_cmplt) begin
                  r_accum <= r_accum - $signed(w_term);
                  if (r_pair == PAIR_OUT) begin
                     r_state  <= CALC;
                     r_led_en <= '0;
                  end else begin
                     r_state   <= SETTLE;
                     r_pair    <= pair_next(r_pair);
                     r_set_cnt <= '0;
                     r_led_en  <= pair_led(pair_next(r_pair));
                  end
               end
            end
            CALC: begin
               r_state   <= SETTLE;
               r_pair    <= PAIR_IN;
               r_set_cnt <= '0;
               r_accum   <= '0;
               r_led_en  <= pair_led(PAIR_IN);
            end
            default: begin
               r_state  <= IDLE;
               r_led_en <= '0;
            end
         endcase
      end
   end

   pi_calc #(
      .INT_DEC   (INT_DEC),
      .BASE_DUTY (BASE_DUTY)
   ) u_pi_calc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_clr),
      .i_calc  (w_calc),
      .i_accum (r_accum),
      .o_error (w_error),
      .o_lft   (w_lft),
      .o_rht   (w_rht),
      .o_vld   (w_vld)
   );

   assign io_seq.strt_cnv  = r_strt_cnv;
   assign io_seq.chnnl     = r_chnnl;
   assign io_seq.IR_in_en  = r_led_en[0];
   assign io_seq.IR_mid_en = r_led_en[1];
   assign io_seq.IR_out_en = r_led_en[2];
   assign io_seq.error     = w_error;
   assign io_seq.lft       = w_lft;
   assign io_seq.rht       = w_rht;
   assign io_seq.err_vld   = w_vld;

endmodule

// File: tb/tb_motion_seq.sv
// Bench for motion_seq: A2D responder with a reference model feeding an expected-result queue.
module tb_motion_seq;
   import motion_pkg::*;

   localparam int unsigned SETTLE = 16;
   localparam int unsigned DEC    = 4;
   localparam int          BASE   = 980;

   logic clk;
   logic rst_n;

   motion_seq_if bus();

   motion_seq #(
      .SETTLE_CYCLES (SETTLE),
      .INT_DEC       (DEC),
      .BASE_DUTY     (11'h3D4)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_seq (bus)
   );

   typedef struct packed {
      logic [11:0] err;
      logic [10:0] lft;
      logic [10:0] rht;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         n_chk;
   int         n_fail;
   int         res_tbl [8];
   int         m_acc, m_dec, m_integ;
   int         seq_idx, pend, n_vld, n_strt;
   int         lat, vld_before, strt_before;
   logic [2:0] pend_ch;
   bit         drop_arm, drop_hit, late_pulse;
   logic [2:0] exp_seq [6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [2:0] exp_led(input logic [2:0] ch);
      case (ch)
         3'd0, 3'd1: return 3'b001;
         3'd2, 3'd4: return 3'b010;
         default:    return 3'b100;
      endcase
   endfunction

   // Reference: right channels add, left subtract, weights x1/x2/x4; outer-left closes a sweep
   task automatic model_sample(input logic [2:0] ch, input int r);
      int e, pi, l, rr;
      case (ch)
         3'd1: m_acc += r;
         3'd0: m_acc -= r;
         3'd4: m_acc += 2 * r;
         3'd2: m_acc -= 2 * r;
         3'd3: m_acc += 4 * r;
         default: m_acc -= 4 * r;
      endcase
      if (ch == 3'd7) begin
         e = sat(m_acc, -2048, 2047);
         m_dec++;
         if (m_dec == DEC) begin
            m_dec   = 0;
            m_integ = sat(m_integ + (e >>> 4), -2048, 2047);
         end
         pi = sat(e + m_integ, -2048, 2047);
         l  = sat(BASE + pi, 0, 2047);
         rr = sat(BASE - pi, 0, 2047);
         sb_q.push_back({12'(e), 11'(l), 11'(rr)});
         m_acc = 0;
      end
   endtask

   // A2D responder: answers each strt_cnv three cycles later, checks channel order and LED group
   initial begin
      bus.cnv_cmplt = 1'b0;
      bus.A2D_res   = '0;
      forever begin
         @(negedge clk);
         bus.cnv_cmplt = 1'b0;
         if (late_pulse) begin
            bus.cnv_cmplt = 1'b1;
            bus.A2D_res   = 12'hFFF;
            late_pulse    = 1'b0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.cnv_cmplt = 1'b1;
               bus.A2D_res   = 12'(res_tbl[pend_ch]);
               model_sample(pend_ch, res_tbl[pend_ch]);
            end
         end
         if (bus.strt_cnv) begin
            n_strt++;
            chk_eq("chnnl", bus.chnnl, exp_seq[seq_idx]);
            chk_eq("led_en", {bus.IR_out_en, bus.IR_mid_en, bus.IR_in_en}, exp_led(bus.chnnl));
            seq_idx = (seq_idx + 1) % 6;
            if (drop_arm && bus.chnnl == 3'd2) begin
               drop_hit = 1'b1;
            end else begin
               pend_ch = bus.chnnl;
               pend    = 3;
            end
         end
      end
   end

   // Result monitor: every err_vld pops one expected sweep result
   initial begin
      forever begin
         @(negedge clk);
         if (bus.err_vld) begin
            n_vld++;
            if (sb_q.size() == 0) begin
               chk_eq("sb_nonempty", sb_q.size(), 1);
            end else begin
               mon_e = sb_q.pop_front();
               chk_eq("error", bus.error, mon_e.err);
               chk_eq("lft", bus.lft, mon_e.lft);
               chk_eq("rht", bus.rht, mon_e.rht);
            end
         end
      end
   end

   task automatic wait_vld(input int n);
      int tgt;
      tgt = n_vld + n;
      for (int i = 0; i < 200 * n && n_vld < tgt; i++) @(posedge clk);
      #1;
      chk_eq("vld_count", n_vld, tgt);
   endtask

   task automatic meas_lat(output int l);
      l = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.strt_cnv) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk_eq({tag, "_leds"}, {bus.IR_out_en, bus.IR_mid_en, bus.IR_in_en}, 3'b000);
      chk_eq({tag, "_strt"}, bus.strt_cnv, 1'b0);
      chk_eq({tag, "_error"}, bus.error, 12'h000);
      chk_eq({tag, "_lft"}, bus.lft, 11'h000);
      chk_eq({tag, "_rht"}, bus.rht, 11'h000);
      chk_eq({tag, "_vld"}, bus.err_vld, 1'b0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      m_acc = 0; m_dec = 0; m_integ = 0;
      seq_idx = 0; pend = 0; n_vld = 0; n_strt = 0;
      drop_arm = 1'b0; drop_hit = 1'b0; late_pulse = 1'b0;
      pend_ch = '0;
      exp_seq[0] = 3'd1; exp_seq[1] = 3'd0; exp_seq[2] = 3'd4;
      exp_seq[3] = 3'd2; exp_seq[4] = 3'd3; exp_seq[5] = 3'd7;
      foreach (res_tbl[i]) res_tbl[i] = 0;
      rst_n  = 1'b0;
      bus.go = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_cleared("reset");
      chk_eq("reset_chnnl", bus.chnnl, 3'd0);
      repeat (10000) @(posedge clk);
      chk_eq("idle_no_strt", n_strt, 0);

      // Mid-scale on every channel: balanced, zero error
      foreach (res_tbl[i]) res_tbl[i] = 'h800;
      @(posedge clk);
      #1 bus.go = 1'b1;
      meas_lat(lat);
      chk_eq("first_strt", lat, SETTLE + 1);
      wait_vld(1);
      chk_eq("mid_error", bus.error, 12'h000);
      chk_eq("mid_lft", bus.lft, 11'h3D4);
      chk_eq("mid_rht", bus.rht, 11'h3D4);
      wait_vld(2);

      // Right full scale, left zero: positive saturation and integrator clamp
      foreach (res_tbl[i]) res_tbl[i] = 0;
      res_tbl[1] = 'hFFF; res_tbl[4] = 'hFFF; res_tbl[3] = 'hFFF;
      wait_vld(1);
      chk_eq("sat_error", bus.error, 12'h7FF);
      chk_eq("sat_lft", bus.lft, 11'h7FF);
      chk_eq("sat_rht", bus.rht, 11'h000);
      wait_vld(79);

      // Negative error exposes the clamped integrator (2047 - 69 = 1978, pi = 878)
      foreach (res_tbl[i]) res_tbl[i] = 0;
      res_tbl[0] = 1100;
      wait_vld(1);
      chk_eq("neg_error", bus.error, 12'hBB4);
      chk_eq("neg_lft", bus.lft, 11'd1858);
      chk_eq("neg_rht", bus.rht, 11'd102);
      wait_vld(3);

      // Drop go while waiting on the mid-left conversion, then deliver a late done pulse
      drop_hit = 1'b0;
      drop_arm = 1'b1;
      for (int i = 0; i < 500 && !drop_hit; i++) @(posedge clk);
      chk_eq("drop_reached", drop_hit, 1'b1);
      #1;
      bus.go      = 1'b0;
      late_pulse  = 1'b1;
      vld_before  = n_vld;
      strt_before = n_strt;
      @(posedge clk);
      #1;
      chk_cleared("drop");
      late_pulse = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk_eq("drop_no_vld", n_vld, vld_before);
      chk_eq("drop_no_strt", n_strt, strt_before);
      drop_arm = 1'b0; drop_hit = 1'b0;
      seq_idx = 0; pend = 0;
      m_acc = 0; m_dec = 0; m_integ = 0;

      // Restart with only channel 1 lit: integrator starts from zero
      foreach (res_tbl[i]) res_tbl[i] = 0;
      res_tbl[1] = 'h100;
      @(posedge clk);
      #1 bus.go = 1'b1;
      meas_lat(lat);
      chk_eq("restart_strt", lat, SETTLE + 1);
      wait_vld(1);
      chk_eq("ch1_error", bus.error, 12'd256);
      chk_eq("ch1_lft", bus.lft, 11'd1236);
      chk_eq("ch1_rht", bus.rht, 11'd724);
      wait_vld(2);
      wait_vld(1);
      chk_eq("ch1_int_lft", bus.lft, 11'd1252);
      chk_eq("ch1_int_rht", bus.rht, 11'd708);
      chk_eq("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
